symm_addsub_seq: RTL and testbench

- Parametrised, sequential successor to the fixed 4x4 matrix subtractor in the FastICA datapath.
- Computes O = A - B or O = A + B element-wise on an N x N signed matrix.
- Processes LANES elements per cycle under a start/busy/done handshake, with optional saturation and an overflow flag.
- Sits between the symmetric-decorrelation multiply stage and the normalisation stage; it lets the same block serve the W - W' update and accumulation steps at reduced adder count.

---
 rtl/symm_pkg.sv | 28 ++
 rtl/addsub_lane.sv | 44 ++++
 rtl/symm_addsub_seq.sv | 136 +++++++++++++
 tb/tb_symm_addsub_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/symm_pkg.sv
// Shared types, mode encodings and sizing helpers for the sequential
// symmetric matrix add/subtract block.
package symm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   // Number of beats needed to sweep an n x n matrix with the given lane count
   function automatic int beats(input int n, input int lanes);
      return (n * n) / lanes;
   endfunction

   // Largest value representable in a w-bit two's complement element
   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   // Smallest value representable in a w-bit two's complement element
   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/addsub_lane.sv
// One arithmetic lane: W-bit signed add or subtract with a one-bit guard,
// overflow detection and optional clamping to the W-bit range.
module addsub_lane
   import symm_pkg::*;
#(
   parameter int W   = 26,
   parameter bit SAT = 1'b1
)(
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic                mode,
   output logic signed [W-1:0] y,
   output logic                ovf
);

   localparam logic signed [W-1:0] MAXV = W'(sat_max(W));
   localparam logic signed [W-1:0] MINV = W'(sat_min(W));

   logic signed [W:0] w_sum;

   // Reduce the guarded sum back to W bits: clamp on overflow when SAT is set,
   // otherwise drop the guard bit and let the value wrap
   function automatic logic signed [W-1:0] narrow(input logic signed [W:0] v);
      if (v[W] == v[W-1]) begin
         return v[W-1:0];
      end else if (SAT) begin
         return v[W] ? MINV : MAXV;
      end else begin
         return v[W-1:0];
      end
   endfunction

   // Guarded add/subtract; the top two bits disagree exactly when W bits overflow
   always_comb begin
      if (mode == MODE_ADD) begin
         w_sum = {a[W-1], a} + {b[W-1], b};
      end else begin
         w_sum = {a[W-1], a} - {b[W-1], b};
      end
      ovf = w_sum[W] ^ w_sum[W-1];
      y   = narrow(w_sum);
   end

endmodule

// File: rtl/symm_addsub_seq.sv
// Sequential N x N signed matrix add/subtract. Operands and mode are
// snapshotted on start, then LANES elements are computed and written into
// the registered result per beat. busy covers the run, done pulses once
// after the last beat, ovf is sticky for the current/last operation.
module symm_addsub_seq
   import symm_pkg::*;
#(
   parameter int N     = 4,
   parameter int W     = 26,
   parameter int LANES = 4,
   parameter bit SAT   = 1'b1
)(
   input  logic             clk_addsub,
   input  logic             rstn_addsub,
   input  logic             start_addsub,
   input  logic             mode_addsub,
   input  logic [N*N*W-1:0] i1,
   input  logic [N*N*W-1:0] i2,
   output logic [N*N*W-1:0] o,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   localparam int ELEMS = N * N;
   localparam int BEATS = beats(N, LANES);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   // The lane count must tile the matrix exactly, otherwise beats would overrun
   if ((ELEMS % LANES) != 0) begin : g_bad_lanes
      $error("symm_addsub_seq: N*N (%0d) is not divisible by LANES (%0d)", ELEMS, LANES);
   end

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_busy;
   logic                r_done;
   logic                r_ovf;
   logic                r_mode;
   logic signed [W-1:0] r_a [ELEMS];
   logic signed [W-1:0] r_b [ELEMS];
   logic signed [W-1:0] r_o [ELEMS];

   logic signed [W-1:0] w_i1 [ELEMS];
   logic signed [W-1:0] w_i2 [ELEMS];
   logic [IDX_W-1:0]    w_idx [LANES];
   logic signed [W-1:0] w_lane_a [LANES];
   logic signed [W-1:0] w_lane_b [LANES];
   logic signed [W-1:0] w_lane_y [LANES];
   logic [LANES-1:0]    w_lane_ovf;

   // Flat row-major buses to and from per-element views
   for (genvar g = 0; g < ELEMS; g++) begin : g_elem
      assign w_i1[g]       = i1[g*W +: W];
      assign w_i2[g]       = i2[g*W +: W];
      assign o[g*W +: W]   = r_o[g];
   end

   // Snapshot mux: lane k works on element cnt*LANES+k of the captured operands
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         w_idx[k]    = IDX_W'(int'(r_cnt) * LANES + k);
         w_lane_a[k] = r_a[w_idx[k]];
         w_lane_b[k] = r_b[w_idx[k]];
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      addsub_lane #(
         .W   (W),
         .SAT (SAT)
      ) u_lane (
         .a    (w_lane_a[k]),
         .b    (w_lane_b[k]),
         .mode (r_mode),
         .y    (w_lane_y[k]),
         .ovf  (w_lane_ovf[k])
      );
   end

   // Control FSM with operand snapshot and beat-by-beat result write-back
   always_ff @(posedge clk_addsub or negedge rstn_addsub) begin
      if (!rstn_addsub) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
         r_mode  <= MODE_SUB;
         r_a     <= '{default: '0};
         r_b     <= '{default: '0};
         r_o     <= '{default: '0};
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start_addsub) begin
                  r_a     <= w_i1;
                  r_b     <= w_i2;
                  r_mode  <= mode_addsub;
                  r_ovf   <= 1'b0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               for (int k = 0; k < LANES; k++) begin
                  r_o[w_idx[k]] <= w_lane_y[k];
               end
               if (|w_lane_ovf) begin
                  r_ovf <= 1'b1;
               end
               if (r_cnt == LAST_BEAT) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_symm_addsub_seq.sv
// Bench for symm_addsub_seq: a saturating and a wrapping 4x4/26-bit instance
// share one stimulus stream, a 3x3/16-bit/3-lane instance runs its own
// random sweep. A transaction-level model predicts every output each cycle.
module tb_symm_addsub_seq;

   localparam int NA = 4, WA = 26, LA = 4, EA = NA * NA, BA = EA / LA;
   localparam int NC = 3, WC = 16, LC = 3, EC = NC * NC, BC = EC / LC;

   logic clk = 1'b0;
   logic rstn;
   logic start_a = 1'b0, mode_a = 1'b0;
   logic start_c = 1'b0, mode_c = 1'b0;
   logic cmp_en = 1'b0;

   logic signed [WA-1:0] ia [EA];
   logic signed [WA-1:0] ib [EA];
   logic signed [WC-1:0] ic1 [EC];
   logic signed [WC-1:0] ic2 [EC];
   logic signed [WA-1:0] os [EA];
   logic signed [WA-1:0] ow [EA];
   logic signed [WC-1:0] oc [EC];

   logic [EA*WA-1:0] i1_a, i2_a, o_s, o_w;
   logic [EC*WC-1:0] i1_c, i2_c, o_c;
   logic busy_s, done_s, ovf_s, busy_w, done_w, ovf_w, busy_c, done_c, ovf_c;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < EA; g++) begin : g_pa
      assign i1_a[g*WA +: WA] = ia[g];
      assign i2_a[g*WA +: WA] = ib[g];
      assign os[g] = o_s[g*WA +: WA];
      assign ow[g] = o_w[g*WA +: WA];
   end
   for (genvar g = 0; g < EC; g++) begin : g_pc
      assign i1_c[g*WC +: WC] = ic1[g];
      assign i2_c[g*WC +: WC] = ic2[g];
      assign oc[g] = o_c[g*WC +: WC];
   end

   symm_addsub_seq #(.N(NA), .W(WA), .LANES(LA), .SAT(1'b1)) dut_s (
      .clk_addsub(clk), .rstn_addsub(rstn), .start_addsub(start_a), .mode_addsub(mode_a),
      .i1(i1_a), .i2(i2_a), .o(o_s), .busy(busy_s), .done(done_s), .ovf(ovf_s));

   symm_addsub_seq #(.N(NA), .W(WA), .LANES(LA), .SAT(1'b0)) dut_w (
      .clk_addsub(clk), .rstn_addsub(rstn), .start_addsub(start_a), .mode_addsub(mode_a),
      .i1(i1_a), .i2(i2_a), .o(o_w), .busy(busy_w), .done(done_w), .ovf(ovf_w));

   symm_addsub_seq #(.N(NC), .W(WC), .LANES(LC), .SAT(1'b1)) dut_c (
      .clk_addsub(clk), .rstn_addsub(rstn), .start_addsub(start_c), .mode_addsub(mode_c),
      .i1(i1_c), .i2(i2_c), .o(o_c), .busy(busy_c), .done(done_c), .ovf(ovf_c));

   // ---------------- reference arithmetic ----------------
   function automatic longint ref_y(input longint a, input longint b, input bit add,
                                    input int w, input bit sat);
      longint r, hi, lo, span;
      span = longint'(1) <<< w;
      hi   = (span >>> 1) - 1;
      lo   = -(span >>> 1);
      r    = add ? a + b : a - b;
      if (r > hi) return sat ? hi : r - span;
      if (r < lo) return sat ? lo : r + span;
      return r;
   endfunction

   function automatic bit ref_ov(input longint a, input longint b, input bit add, input int w);
      longint r, span;
      span = longint'(1) <<< w;
      r    = add ? a + b : a - b;
      return (r > (span >>> 1) - 1) || (r < -(span >>> 1));
   endfunction

   function automatic longint rnd(input int w);
      longint hi;
      hi = (longint'(1) <<< (w - 1)) - 1;
      case ($urandom_range(7))
         0: return hi;
         1: return -hi - 1;
         default: return longint'($urandom_range(32'((longint'(1) <<< w) - 1))) - (hi + 1);
      endcase
   endfunction

   task automatic chk(input string nm, input int idx, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         if (idx >= 0) $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
         else          $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int nz_a();
      int n;
      n = 0;
      for (int e = 0; e < EA; e++) if (os[e] != 0 || ow[e] != 0) n++;
      return n;
   endfunction

   // ---------------- transaction model, 4x4 pair ----------------
   // On accept the whole result matrix is computed; each later edge reveals
   // the next group of LANES elements until all are visible.
   longint xs [EA], xw [EA], rs [EA], rw [EA];
   bit     ev_a [EA];
   bit     act_a, mb_a, md_a, mo_a;
   int     ph_a;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int e = 0; e < EA; e++) begin
            xs[e] <= 0;
            xw[e] <= 0;
         end
         act_a <= 1'b0; ph_a <= 0; mb_a <= 1'b0; md_a <= 1'b0; mo_a <= 1'b0;
      end else begin
         md_a <= 1'b0;
         if (act_a) begin
            for (int e = 0; e < EA; e++) begin
               if (e / LA == ph_a) begin
                  xs[e] <= rs[e];
                  xw[e] <= rw[e];
                  if (ev_a[e]) mo_a <= 1'b1;
               end
            end
            ph_a <= ph_a + 1;
            if (ph_a == BA - 1) begin
               act_a <= 1'b0; mb_a <= 1'b0; md_a <= 1'b1;
            end
         end else if (start_a) begin
            for (int e = 0; e < EA; e++) begin
               rs[e]   <= ref_y(ia[e], ib[e], mode_a, WA, 1'b1);
               rw[e]   <= ref_y(ia[e], ib[e], mode_a, WA, 1'b0);
               ev_a[e] <= ref_ov(ia[e], ib[e], mode_a, WA);
            end
            mo_a <= 1'b0; act_a <= 1'b1; ph_a <= 0; mb_a <= 1'b1;
         end
      end
   end

   // ---------------- transaction model, 3x3 instance ----------------
   longint xc [EC], rc [EC];
   bit     ev_c [EC];
   bit     act_c, mb_c, md_c, mo_c;
   int     ph_c;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int e = 0; e < EC; e++) xc[e] <= 0;
         act_c <= 1'b0; ph_c <= 0; mb_c <= 1'b0; md_c <= 1'b0; mo_c <= 1'b0;
      end else begin
         md_c <= 1'b0;
         if (act_c) begin
            for (int e = 0; e < EC; e++) begin
               if (e / LC == ph_c) begin
                  xc[e] <= rc[e];
                  if (ev_c[e]) mo_c <= 1'b1;
               end
            end
            ph_c <= ph_c + 1;
            if (ph_c == BC - 1) begin
               act_c <= 1'b0; mb_c <= 1'b0; md_c <= 1'b1;
            end
         end else if (start_c) begin
            for (int e = 0; e < EC; e++) begin
               rc[e]   <= ref_y(ic1[e], ic2[e], mode_c, WC, 1'b1);
               ev_c[e] <= ref_ov(ic1[e], ic2[e], mode_c, WC);
            end
            mo_c <= 1'b0; act_c <= 1'b1; ph_c <= 0; mb_c <= 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int e = 0; e < EA; e++) begin
            chk("sat o", e, os[e], xs[e]);
            chk("wrap o", e, ow[e], xw[e]);
         end
         chk("sat busy", -1, busy_s, mb_a);
         chk("sat done", -1, done_s, md_a);
         chk("sat ovf", -1, ovf_s, mo_a);
         chk("wrap busy", -1, busy_w, mb_a);
         chk("wrap done", -1, done_w, md_a);
         chk("wrap ovf", -1, ovf_w, mo_a);
         for (int e = 0; e < EC; e++) chk("c3 o", e, oc[e], xc[e]);
         chk("c3 busy", -1, busy_c, mb_c);
         chk("c3 done", -1, done_c, md_c);
         chk("c3 ovf", -1, ovf_c, mo_c);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic op_a(input bit md, output int edges, output bit busy_first);
      start_a = 1'b1;
      mode_a  = md;
      @(negedge clk);
      start_a    = 1'b0;
      edges      = 1;
      busy_first = busy_s;
      while (done_s !== 1'b1 && edges < 20) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic op_c(input bit md, output int edges);
      start_c = 1'b1;
      mode_c  = md;
      @(negedge clk);
      start_c = 1'b0;
      edges   = 1;
      while (done_c !== 1'b1 && edges < 20) begin
         @(negedge clk);
         edges++;
      end
   endtask

   // ---------------- directed and random sequence ----------------
   initial begin
      int edges, ndone;
      bit bf;
      for (int e = 0; e < EA; e++) begin ia[e] = '0; ib[e] = '0; end
      for (int e = 0; e < EC; e++) begin ic1[e] = '0; ic2[e] = '0; end

      rstn = 1'b1;
      #1 rstn = 1'b0;
      #1;
      chk("reset o", -1, nz_a(), 0);
      chk("reset busy", -1, busy_s, 0);
      chk("reset done", -1, done_s, 0);
      chk("reset ovf", -1, ovf_s, 0);
      repeat (2) @(negedge clk);
      rstn   = 1'b1;
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle o", -1, nz_a(), 0);

      // subtract: A(r,c) = 100r + c, B = 5
      for (int r = 0; r < NA; r++)
         for (int c = 0; c < NA; c++) begin
            ia[r*NA+c] = WA'(100 * r + c);
            ib[r*NA+c] = WA'(5);
         end
      start_a = 1'b1; mode_a = 1'b0;
      @(negedge clk); start_a = 1'b0;
      chk("sub busy after E0", -1, busy_s, 1);
      chk("sub o(0,0) after E0", -1, os[0], 0);
      @(negedge clk);
      chk("sub o(0,0) after E1", -1, os[0], -5);
      chk("sub o(0,3) after E1", -1, os[3], -2);
      chk("sub o(3,0) after E1", -1, os[12], 0);
      repeat (2) @(negedge clk);
      chk("sub busy after E3", -1, busy_s, 1);
      chk("sub done after E3", -1, done_s, 0);
      chk("sub o(3,0) after E3", -1, os[12], 0);
      @(negedge clk);
      chk("sub done after E4", -1, done_s, 1);
      chk("sub busy after E4", -1, busy_s, 0);
      chk("sub o(2,3)", -1, os[11], 198);
      chk("sub o(3,0)", -1, os[12], 295);
      chk("sub wrap o(2,3)", -1, ow[11], 198);
      @(negedge clk);
      chk("sub done clears", -1, done_s, 0);

      // abort mid-run after two beats
      for (int e = 0; e < EA; e++) begin ia[e] = WA'(7); ib[e] = WA'(3); end
      start_a = 1'b1; mode_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort partial o(0,0)", -1, os[0], 10);
      #2 rstn = 1'b0;
      #1;
      chk("abort o", -1, nz_a(), 0);
      chk("abort busy", -1, busy_s, 0);
      chk("abort done", -1, done_s, 0);
      chk("abort ovf", -1, ovf_s, 0);
      @(negedge clk); rstn = 1'b1;
      repeat (4) @(negedge clk);
      chk("post-abort o", -1, nz_a(), 0);
      chk("post-abort busy", -1, busy_s, 0);

      // positive overflow on add
      for (int e = 0; e < EA; e++) begin ia[e] = '0; ib[e] = '0; end
      ia[0] = WA'(33554431); ib[0] = WA'(1);
      op_a(1'b1, edges, bf);
      chk("latency add", -1, edges, 5);
      chk("sat o(0,0)", -1, os[0], 33554431);
      chk("wrap o(0,0)", -1, ow[0], -33554432);
      chk("sat ovf", -1, ovf_s, 1);
      chk("wrap ovf", -1, ovf_w, 1);

      // negative overflow on subtract, started in the done cycle
      ia[0] = '0; ib[0] = '0;
      ia[5] = WA'(-33554432); ib[5] = WA'(1);
      op_a(1'b0, edges, bf);
      chk("back-to-back busy", -1, bf, 1);
      chk("back-to-back latency", -1, edges, 5);
      chk("sat o(1,1)", -1, os[5], -33554432);
      chk("wrap o(1,1)", -1, ow[5], 33554431);
      chk("sat o(0,0) cleared", -1, os[0], 0);
      chk("sat ovf neg", -1, ovf_s, 1);

      // clean operation clears ovf
      for (int e = 0; e < EA; e++) begin ia[e] = WA'(e); ib[e] = WA'(1); end
      op_a(1'b1, edges, bf);
      chk("clean ovf sat", -1, ovf_s, 0);
      chk("clean ovf wrap", -1, ovf_w, 0);
      chk("clean o(3,3)", -1, os[15], 16);

      // inputs changed and start pulsed while running
      @(negedge clk);
      for (int e = 0; e < EA; e++) begin ia[e] = WA'(rnd(WA)); ib[e] = WA'(rnd(WA)); end
      start_a = 1'b1; mode_a = 1'($urandom_range(1));
      @(negedge clk); start_a = 1'b0;
      @(negedge clk);
      for (int e = 0; e < EA; e++) begin ia[e] = WA'(rnd(WA)); ib[e] = WA'(rnd(WA)); end
      start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         if (done_s) ndone++;
         @(negedge clk);
      end
      chk("ignored start done count", -1, ndone, 1);

      // random traffic on the 4x4 pair
      for (int t = 0; t < 1500; t++) begin
         start_a = ($urandom_range(2) == 0);
         mode_a  = 1'($urandom_range(1));
         if ($urandom_range(1) == 1)
            for (int e = 0; e < EA; e++) begin ia[e] = WA'(rnd(WA)); ib[e] = WA'(rnd(WA)); end
         @(negedge clk);
      end
      start_a = 1'b0;
      repeat (8) @(negedge clk);

      // 3x3 / 3 lanes / 16 bit
      for (int e = 0; e < EC; e++) begin ic1[e] = WC'(1000); ic2[e] = WC'(7); end
      op_c(1'b0, edges);
      chk("c3 latency first", -1, edges, 4);
      chk("c3 o(2,2)", -1, oc[8], 993);
      for (int t = 0; t < 1000; t++) begin
         for (int e = 0; e < EC; e++) begin ic1[e] = WC'(rnd(WC)); ic2[e] = WC'(rnd(WC)); end
         op_c(1'($urandom_range(1)), edges);
         chk("c3 latency", -1, edges, 4);
      end
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
